seg_display_sched: RTL and testbench

SEG_DISPLAY_SCHED -- requirements
Module: seg_display_sched

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_display_sched_bin2bcd.sv | 63 ++++++
 rtl/seg_display_sched.sv | 126 ++++++++++++
 tb/tb_seg_display_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scheduler.
package seg_pkg;

    typedef enum logic {
        SHOW_SCORE = 1'b0,
        SHOW_ALERT = 1'b1
    } owner_e;

    typedef logic [3:0] bcd_t;

    localparam logic [3:0]  COM_OFF   = 4'b1111;
    localparam logic [3:0]  COM_DIG0  = 4'b1110;
    localparam logic [3:0]  COM_DIG1  = 4'b1101;
    localparam logic [3:0]  COM_DIG2  = 4'b1011;
    localparam logic [3:0]  COM_DIG3  = 4'b0111;
    localparam logic [13:0] SCORE_MAX = 14'd9999;

    function automatic logic [3:0] com_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = COM_DIG0;
            2'd1:    pat = COM_DIG1;
            2'd2:    pat = COM_DIG2;
            default: pat = COM_DIG3;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_display_sched_bin2bcd.sv
// Sequential double-dabble converter: 14-bit binary to four BCD digits.
// Start is taken only when idle; done is high in the cycle before busy drops, 15 cycles after start.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [13:0] bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        adj    = bcd_q;
        if (busy_q) begin
            if (cnt_q != 4'd0) begin
                for (int i = 0; i < 4; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q - 4'd1;
            end else begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = 4'd14;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == 4'd0);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_display_sched.sv
// 4-digit display scheduler: score vs alert ownership, scan multiplexing, background BCD conversion.
// Optional SEG_LEADING_ZERO_BLANK_EN darkens leading zeros of the score; otherwise blank stays 0.
module seg_display_sched
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned HOLD_FRAMES = 2000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [13:0] score,
    input  logic        alert_req,
    input  logic [15:0] alert_digits,
    output logic        alert_ack,
    output logic [3:0]  COM,
    output logic [3:0]  bcd_out,
    output logic        blank,
    output logic        showing_alert
);

    localparam int unsigned DIV = CLK_HZ / (SCAN_HZ * 4);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FW  = $clog2(HOLD_FRAMES + 1);

    owner_e      owner_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]  idx_q;
    logic [FW-1:0] frame_q, frame_d;
    logic [15:0] alert_dig_q, score_dig_q;
    logic [13:0] last_q, score_clamped;
    logic [3:0]  com_q;
    bcd_t        bcd_q, disp_dig;
    logic        blank_q, blank_d, ack_q;
    logic [15:0] disp_src, conv_bcd;
    logic        tick, conv_start, conv_busy, conv_done;

    assign tick          = (presc_q == PW'(DIV - 1));
    assign presc_d       = tick ? '0 : presc_q + PW'(1);
    assign frame_d       = frame_q + FW'(1);
    assign score_clamped = (score > SCORE_MAX) ? SCORE_MAX : score;
    assign conv_start    = (score_clamped != last_q) && !conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .start_i (conv_start),
        .bin_i   (score_clamped),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // idx_q is the digit that the next scan tick will enable.
    always_comb begin
        disp_src = (owner_q == SHOW_ALERT) ? alert_dig_q : score_dig_q;
        disp_dig = disp_src[{idx_q, 2'b00} +: 4];
        blank_d  = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (owner_q == SHOW_SCORE) begin
            case (idx_q)
                2'd1:    blank_d = (score_dig_q[15:4] == 12'd0);
                2'd2:    blank_d = (score_dig_q[15:8] == 8'd0);
                2'd3:    blank_d = (score_dig_q[15:12] == 4'd0);
                default: blank_d = 1'b0;
            endcase
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            owner_q     <= SHOW_SCORE;
            presc_q     <= '0;
            idx_q       <= 2'd0;
            frame_q     <= '0;
            alert_dig_q <= '0;
            score_dig_q <= '0;
            last_q      <= '0;
            com_q       <= COM_OFF;
            bcd_q       <= '0;
            blank_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ack_q   <= 1'b0;
            if (tick) begin
                idx_q   <= idx_q + 2'd1;
                com_q   <= com_pattern(idx_q);
                bcd_q   <= disp_dig;
                blank_q <= blank_d;
            end
            if (conv_done)  score_dig_q <= conv_bcd;
            if (conv_start) last_q      <= score_clamped;
            case (owner_q)
                SHOW_SCORE: begin
                    if (alert_req) begin
                        alert_dig_q <= alert_digits;
                        ack_q       <= 1'b1;
                        frame_q     <= '0;
                        owner_q     <= SHOW_ALERT;
                    end
                end
                SHOW_ALERT: begin
                    // A frame completes on the tick that wraps digit 3 back to 0.
                    if (tick && idx_q == 2'd3) begin
                        if (frame_d == FW'(HOLD_FRAMES)) begin
                            frame_q <= '0;
                            owner_q <= SHOW_SCORE;
                        end else begin
                            frame_q <= frame_d;
                        end
                    end
                end
                default: owner_q <= SHOW_SCORE;
            endcase
        end
    end

    assign COM           = com_q;
    assign bcd_out       = bcd_q;
    assign blank         = blank_q;
    assign alert_ack     = ack_q;
    assign showing_alert = (owner_q == SHOW_ALERT);

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed plus randomized bench for seg_display_sched against an edge-count arithmetic model.
module tb_seg_display_sched;

    localparam int unsigned CLK_HZ  = 4000;
    localparam int unsigned SCAN_HZ = 250;
    localparam int unsigned HOLD    = 2;
    localparam int DIV   = CLK_HZ / (SCAN_HZ * 4);
    localparam int FRAME = 4 * DIV;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [13:0] score = '0;
    logic        alert_req = 1'b0;
    logic [15:0] alert_digits = '0;
    logic        alert_ack, blank, showing_alert;
    logic [3:0]  COM, bcd_out;

    int n_cmp = 0;
    int n_err = 0;

    seg_display_sched #(
        .CLK_HZ      (CLK_HZ),
        .SCAN_HZ     (SCAN_HZ),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .score         (score),
        .alert_req     (alert_req),
        .alert_digits  (alert_digits),
        .alert_ack     (alert_ack),
        .COM           (COM),
        .bcd_out       (bcd_out),
        .blank         (blank),
        .showing_alert (showing_alert)
    );

    always #5 CLK = ~CLK;

    // Reference model: everything derived from the edge count k since reset.
    // Scan ticks land on multiples of DIV, frame wraps on multiples of FRAME,
    // a conversion captured at edge k shows up in the score digits at edge k+15.
    int          k, m_last, m_val, m_pend, m_done, a_edge, r_edge, idx;
    bit          prev_alert;
    logic [15:0] m_alert;
    logic [3:0]  e_com = 4'hF, e_bcd = '0;
    logic        e_blank = 1'b0, e_ack = 1'b0, e_show = 1'b0;

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    always @(posedge CLK) begin
        if (!RST_N) begin
            k = 0; m_last = 0; m_val = 0; m_pend = 0; m_done = -1;
            a_edge = -1; r_edge = -1; m_alert = '0;
            e_com = 4'hF; e_bcd = '0; e_blank = 1'b0; e_ack = 1'b0; e_show = 1'b0;
        end else begin
            k++;
            prev_alert = (a_edge >= 0) && (a_edge <= k - 1) && (k - 1 < r_edge);
            if (k % DIV == 0) begin
                idx      = (k / DIV - 1) % 4;
                e_com    = 4'hF;
                e_com[idx] = 1'b0;
                if (prev_alert) begin
                    e_bcd   = m_alert[idx*4 +: 4];
                    e_blank = 1'b0;
                end else begin
                    e_bcd = 4'((m_val / pow10(idx)) % 10);
`ifdef SEG_LEADING_ZERO_BLANK_EN
                    e_blank = (idx > 0) && (m_val < pow10(idx));
`else
                    e_blank = 1'b0;
`endif
                end
            end
            if (k == m_done) m_val = m_pend;
            if (m_done < k && clampv(int'(score)) != m_last) begin
                m_last = clampv(int'(score));
                m_pend = m_last;
                m_done = k + 15;
            end
            if (!prev_alert && alert_req) begin
                a_edge  = k;
                r_edge  = (k / FRAME + int'(HOLD)) * FRAME;
                m_alert = alert_digits;
            end
            e_ack  = (k == a_edge);
            e_show = (a_edge >= 0) && (a_edge <= k) && (k < r_edge);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("COM",           16'(COM),           16'(e_com));
            chk("bcd_out",       16'(bcd_out),       16'(e_bcd));
            chk("blank",         16'(blank),         16'(e_blank));
            chk("alert_ack",     16'(alert_ack),     16'(e_ack));
            chk("showing_alert", 16'(showing_alert), 16'(e_show));
        end
    endtask

    int r;

    initial begin
        // reset state, then the bare COM rotation with score 0
        RST_N = 1'b0;
        step(3);
        RST_N = 1'b1;
        step(40);

        score = 14'd1234;
        step(64);

        // every digit differs between neighbours; shifting phase exposes the 15-cycle latency
        score = 14'd5678; step(20);
        score = 14'd1234; step(21);
        score = 14'd6789; step(22);
        score = 14'd2345; step(23);
        step(30);

        // clamp, and a change during conversion that must be picked up afterwards
        score = 14'd12000; step(5);
        score = 14'd5;     step(70);

        score = 14'd7;
        step(48);

        // alert ownership with a held request: ack, hold for HOLD frames, re-ack after return
        alert_digits = 16'h0042;
        alert_req    = 1'b1;
        step(90);
        alert_req    = 1'b0;
        step(60);

        // reset in the middle of an alert and a conversion
        alert_digits = 16'h0913;
        alert_req    = 1'b1;
        score        = 14'd4321;
        step(3);
        alert_req    = 1'b0;
        step(2);
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
        step(40);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) score = 14'($urandom_range(0, 16383));
            else if (r < 16) score = 14'($urandom_range(0, 120));
            if (r >= 20 && r < 30) alert_req = ~alert_req;
            alert_digits = 16'($urandom);
            RST_N = (r == 99) ? 1'b0 : 1'b1;
            step(int'($urandom_range(1, 8)));
        end
        RST_N = 1'b1;
        step(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
